// File: rtl/motion_update_sequencer_pkg.sv
// Shared types and game constants for the per-frame motion update sequencer.
//   - FSM state encoding (3-bit)
//   - game constants (player range, speeds, bounce and heart-pulse limits)
//   - committed/shadow game-state payload struct
//   - small RGB pixel helper used by the renderer side
package motion_update_sequencer_pkg;

  localparam int unsigned POS_W   = 12;  // pxm / pym, 2 fractional bits on X
  localparam int unsigned VEL_W   = 8;   // signed Y velocity
  localparam int unsigned HEART_W = 11;  // heart radius^2 threshold
  localparam int unsigned OUT_W   = 10;  // px / py
  localparam int unsigned STATE_W = 3;
  localparam int unsigned RGB_W   = 2;

  localparam logic [POS_W-1:0]   RANGE_X     = POS_W'(608);
  localparam logic [POS_W-1:0]   SPEED_X     = POS_W'(9);
  localparam logic [VEL_W-1:0]   INIT_VEL_Y  = VEL_W'(21);
  localparam logic [VEL_W-1:0]   BOUNCE_BASE = VEL_W'(19);
  localparam logic [HEART_W-1:0] PULSE_INIT  = HEART_W'(9);
  localparam logic [POS_W-1:0]   PULSE_STEP  = POS_W'(10);
  localparam logic [POS_W-1:0]   PULSE_MIN   = POS_W'(20);
  localparam logic [POS_W-1:0]   PULSE_MAX   = POS_W'(200);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_X_ADD  = 3'd1,
    ST_X_DIR  = 3'd2,
    ST_Y_ADD  = 3'd3,
    ST_PULSE  = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  // Full game state; used both for the committed copy and the shadow copy.
  typedef struct packed {
    logic [POS_W-1:0]   pxm;    // X position, 2 fractional bits
    logic [POS_W-1:0]   pym;    // height above grass
    logic [VEL_W-1:0]   vel;    // signed Y velocity
    logic               dx;     // 1 = moving right
    logic [HEART_W-1:0] heart;  // heart radius^2 threshold
    logic               pdir;   // 1 = pulse growing
  } motion_state_t;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  function automatic rgb_t rgb(input logic [RGB_W-1:0] rr,
                               input logic [RGB_W-1:0] gg,
                               input logic [RGB_W-1:0] bb);
    rgb_t c;
    c.r = rr;
    c.g = gg;
    c.b = bb;
    return c;
  endfunction

endpackage

// File: rtl/motion_update_sequencer_alu.sv
// Shared 12-bit adder/subtractor with compare flags for the motion sequencer.
// Ports:
//   a_i, b_i   : adder operands, sum_c_o = a_i + b_i (or a_i - b_i when sub_i)
//   c_i        : compare operand for ge_c_o
//   ge_c_o     : a_i >= c_i (unsigned)
//   eq0_c_o    : a_i == 0
//   le0_c_o    : sum_c_o <= 0 when read as signed
module motion_alu
  import motion_update_sequencer_pkg::*;
(
  input  logic [POS_W-1:0] a_i,
  input  logic [POS_W-1:0] b_i,
  input  logic [POS_W-1:0] c_i,
  input  logic             sub_i,
  output logic [POS_W-1:0] sum_c_o,
  output logic             ge_c_o,
  output logic             eq0_c_o,
  output logic             le0_c_o
);

  // Single carry chain: subtraction as a + ~b + 1.
  assign sum_c_o = a_i + (sub_i ? ~b_i : b_i) + POS_W'(sub_i);
  assign ge_c_o  = (a_i >= c_i);
  assign eq0_c_o = (a_i == '0);
  assign le0_c_o = sum_c_o[POS_W-1] | (sum_c_o == '0);

endmodule

// File: rtl/motion_update_sequencer.sv
// Per-frame scheduler for the bouncing-player game state. Each accepted
// frame_end steps one shared adder through X move, X wall check, Y bounce
// and heart pulse on a shadow copy, then commits everything in one edge.
// Ports:
//   clk, reset        : pixel clock, synchronous active-high reset
//   frame_end, pause  : update request pulse; pause drops the request
//   px, py, heart_r2  : committed outputs for the renderer
//   busy              : sequence in progress
//   done              : 1-cycle pulse, first cycle new values are visible
//   overrun           : 1-cycle pulse after a frame_end arrived while busy
module motion_update_sequencer
  import motion_update_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_end,
  input  logic               pause,
  output logic [OUT_W-1:0]   px,
  output logic [OUT_W-1:0]   py,
  output logic [HEART_W-1:0] heart_r2,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  state_e        state_q, state_d;
  motion_state_t cur_q, cur_d;
  motion_state_t sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  logic [POS_W-1:0] alu_a, alu_b, alu_c;
  logic             alu_sub;
  logic [POS_W-1:0] alu_sum;
  logic             alu_ge, alu_eq0, alu_le0;

  motion_alu u_alu (
    .a_i     (alu_a),
    .b_i     (alu_b),
    .c_i     (alu_c),
    .sub_i   (alu_sub),
    .sum_c_o (alu_sum),
    .ge_c_o  (alu_ge),
    .eq0_c_o (alu_eq0),
    .le0_c_o (alu_le0)
  );

  function automatic motion_state_t reset_state();
    motion_state_t s;
    s.pxm   = '0;
    s.pym   = '0;
    s.vel   = INIT_VEL_Y;
    s.dx    = 1'b1;
    s.heart = PULSE_INIT;
    s.pdir  = 1'b1;
    return s;
  endfunction

  // Next-state, operand muxing and shadow updates.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    sh_d      = sh_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_c     = '0;
    alu_sub   = 1'b0;
    done_d    = 1'b0;
    overrun_d = frame_end & (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_end && !pause) begin
          state_d = ST_X_ADD;
          sh_d    = cur_q;
        end
      end
      ST_X_ADD: begin
        alu_a    = sh_q.pxm;
        alu_b    = SPEED_X;
        alu_sub  = ~sh_q.dx;
        sh_d.pxm = alu_sum;
        state_d  = ST_X_DIR;
      end
      ST_X_DIR: begin
        // Wall check on the integer part of the freshly moved X.
        alu_a = POS_W'(sh_q.pxm[POS_W-1:2]);
        alu_c = RANGE_X;
        if (alu_ge) begin
          sh_d.dx = 1'b0;
        end else if (alu_eq0) begin
          sh_d.dx = 1'b1;
        end
        state_d = ST_Y_ADD;
      end
      ST_Y_ADD: begin
        alu_a = sh_q.pym;
        alu_b = {{(POS_W-VEL_W){sh_q.vel[VEL_W-1]}}, sh_q.vel};
        // pym + vel <= 0 is pym <= -vel; no overflow while pym < 256.
        if (sh_q.vel[VEL_W-1] && (sh_q.pym[POS_W-1:8] == '0) && alu_le0) begin
          sh_d.pym = '0;
          sh_d.vel = BOUNCE_BASE + VEL_W'(cur_q.pxm[3:2]);
        end else begin
          sh_d.pym = alu_sum;
          sh_d.vel = sh_q.vel - VEL_W'(1);
        end
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        alu_a   = POS_W'(sh_q.heart);
        alu_b   = PULSE_STEP;
        alu_sub = ~sh_q.pdir;
        alu_c   = sh_q.pdir ? PULSE_MAX : PULSE_MIN;
        if (sh_q.pdir) begin
          if (alu_ge) sh_d.pdir  = 1'b0;
          else        sh_d.heart = alu_sum[HEART_W-1:0];
        end else begin
          if (!alu_ge) sh_d.pdir  = 1'b1;
          else         sh_d.heart = alu_sum[HEART_W-1:0];
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        cur_d   = sh_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cur_q     <= reset_state();
      sh_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      sh_q      <= sh_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign px       = cur_q.pxm[POS_W-1:2];
  assign py       = cur_q.pym[OUT_W-1:0];
  assign heart_r2 = cur_q.heart;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_motion_update_sequencer.sv
// Self-checking bench for motion_update_sequencer: directed game-rule scenarios
// plus randomized frame_end/pause/reset traffic against a frame-level model.
module tb_motion_update_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_end = 1'b0;
  logic        pause = 1'b0;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [10:0] heart_r2;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Frame-level reference state
  int m_pxm, m_pym, m_vel, m_dx, m_heart, m_pdir;
  int p_pxm, p_pym, p_vel, p_dx, p_heart, p_pdir;
  int rem;            // cycles until pending results commit
  int exp_busy, exp_done, exp_ovr;

  motion_update_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .frame_end (frame_end),
    .pause     (pause),
    .px        (px),
    .py        (py),
    .heart_r2  (heart_r2),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // One frame of game rules applied to the committed state.
  task automatic model_compute();
    int npx;
    p_pxm = (m_pxm + (m_dx != 0 ? 9 : -9)) & 12'hFFF;
    npx   = p_pxm / 4;
    if (npx >= 608)   p_dx = 0;
    else if (npx == 0) p_dx = 1;
    else              p_dx = m_dx;
    if (m_vel < 0 && m_pym < 256 && m_pym <= -m_vel) begin
      p_pym = 0;
      p_vel = 19 + ((m_pxm / 4) % 4);
    end else begin
      p_pym = (m_pym + m_vel) & 12'hFFF;
      p_vel = m_vel - 1;
    end
    p_heart = m_heart;
    p_pdir  = m_pdir;
    if (m_pdir != 0) begin
      if (m_heart >= 200) p_pdir = 0;
      else                p_heart = m_heart + 10;
    end else begin
      if (m_heart < 20)   p_pdir = 1;
      else                p_heart = m_heart - 10;
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at it.
  task automatic model_step(input bit fe, input bit pa, input bit rst);
    exp_done = 0;
    exp_ovr  = 0;
    if (rst) begin
      m_pxm = 0; m_pym = 0; m_vel = 21; m_dx = 1; m_heart = 9; m_pdir = 1;
      rem = 0;
    end else begin
      exp_ovr = (fe && rem > 0) ? 1 : 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_pxm = p_pxm; m_pym = p_pym; m_vel = p_vel;
          m_dx = p_dx; m_heart = p_heart; m_pdir = p_pdir;
          exp_done = 1;
        end
      end else if (fe && !pa) begin
        model_compute();
        rem = 5;
      end
    end
    exp_busy = (rem > 0) ? 1 : 0;
  endtask

  task automatic drive(input bit fe, input bit pa, input bit rst);
    frame_end = fe;
    pause     = pa;
    reset     = rst;
    @(posedge clk);
    model_step(fe, pa, rst);
    #1;
  endtask

  task automatic do_frame();
    drive(1'b1, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("px",       int'(px),       m_pxm / 4);
      chk("py",       int'(py),       m_pym % 1024);
      chk("heart_r2", int'(heart_r2), m_heart);
      chk("busy",     int'(busy),     exp_busy);
      chk("done",     int'(done),     exp_done);
      chk("overrun",  int'(overrun),  exp_ovr);
    end
  end

  initial begin
    // Reset held for three cycles
    drive(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("rst_px", int'(px), 0);
    chk("rst_py", int'(py), 0);
    chk("rst_heart", int'(heart_r2), 9);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // First frame: busy for five cycles, done in the sixth
    drive(1'b1, 1'b0, 1'b0);
    chk("f1_busy_first", int'(busy), 1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    chk("f1_busy_last", int'(busy), 1);
    chk("f1_px_held", int'(px), 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("f1_done", int'(done), 1);
    chk("f1_busy_clear", int'(busy), 0);
    chk("f1_px", int'(px), 2);
    chk("f1_py", int'(py), 21);
    chk("f1_heart", int'(heart_r2), 19);
    drive(1'b0, 1'b0, 1'b0);
    chk("f1_done_pulse", int'(done), 0);

    // Frames 2..272 with pinned values at the interesting points
    for (int f = 2; f <= 272; f++) begin
      do_frame();
      case (f)
        20:  chk("f20_heart", int'(heart_r2), 209);
        21:  chk("f21_heart_flip", int'(heart_r2), 209);
        22:  chk("f22_heart", int'(heart_r2), 199);
        43:  chk("f43_land_py", int'(py), 0);
        44:  chk("f44_bounce_py", int'(py), 21);
        271: chk("f271_px", int'(px), 609);
        272: chk("f272_px", int'(px), 607);
        default: ;
      endcase
    end

    // Overrun: second frame_end two cycles later is dropped
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("ovr_pulse", int'(overrun), 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("ovr_clear", int'(overrun), 0);
    repeat (10) drive(1'b0, 1'b0, 1'b0);
    chk("ovr_single_update_px", int'(px), 605);

    // Pause drops the request
    drive(1'b1, 1'b1, 1'b0);
    chk("pause_busy", int'(busy), 0);
    repeat (7) drive(1'b0, 1'b0, 1'b0);
    chk("pause_px", int'(px), 605);

    // Reset in the middle of a sequence
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("midrst_px", int'(px), 0);
    chk("midrst_heart", int'(heart_r2), 9);
    chk("midrst_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("midrst_no_done", int'(done), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 2500) == 0);
    end
    repeat (8) drive(1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
